// File: rtl/dm_resp_if.sv
// rtl/dm_resp_if.sv - MEM-stage data port between the CPU requester and dm_resp
interface dm_resp_if;
    logic [15:0] addr;
    logic        re;
    logic        we;
    logic [15:0] wrt_data;
    logic [15:0] rd_data;
    logic        busy;
    logic        wb_empty;

    modport master (
        output addr,
        output re,
        output we,
        output wrt_data,
        input  rd_data,
        input  busy,
        input  wb_empty
    );

    modport slave (
        input  addr,
        input  re,
        input  we,
        input  wrt_data,
        output rd_data,
        output busy,
        output wb_empty
    );
endinterface

// File: rtl/dm_resp.sv
// rtl/dm_resp.sv - data-memory responder: posted-store FIFO drained into a word array
// DM_RESP_FWD_EN: forward buffered stores to loads; otherwise loads hitting the buffer stall.
module dm_resp #(
    parameter int MEM_AW    = 16,
    parameter int WB_DEPTH  = 4,
    parameter int DRAIN_CYC = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    dm_resp_if.slave bus
);
    localparam int PW  = $clog2(WB_DEPTH);
    localparam int CW  = $clog2(WB_DEPTH + 1);
    localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    logic [15:0]       mem     [1 << MEM_AW];
    logic [MEM_AW-1:0] wb_addr [WB_DEPTH];
    logic [15:0]       wb_data [WB_DEPTH];

    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW-1:0]     idx;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic [CW-1:0]     count_after_pop;
    state_t            state;
    state_t            state_nxt;
    logic [DCW-1:0]    drain_cnt;
    logic [DCW-1:0]    drain_cnt_nxt;
    logic [MEM_AW-1:0] ld_addr;
    logic              full;
    logic              push;
    logic              pop;
    logic              hit;
`ifdef DM_RESP_FWD_EN
    logic [15:0]       fwd_data;
`endif

    assign ld_addr = bus.addr[MEM_AW-1:0];
    assign full    = (count == CW'(WB_DEPTH));

    // Walk from head to tail so the last match seen is the newest store to that address.
    always_comb begin
        hit = 1'b0;
        idx = '0;
`ifdef DM_RESP_FWD_EN
        fwd_data = '0;
`endif
        for (int j = 0; j < WB_DEPTH; j++) begin
            idx = head + PW'(j);
            if ((CW'(j) < count) && (wb_addr[idx] == ld_addr)) begin
                hit = 1'b1;
`ifdef DM_RESP_FWD_EN
                fwd_data = wb_data[idx];
`endif
            end
        end
    end

`ifdef DM_RESP_FWD_EN
    assign bus.busy    = rst_n & bus.we & full;
    assign bus.rd_data = (rst_n & bus.re) ? (hit ? fwd_data : mem[ld_addr]) : 16'h0000;
`else
    assign bus.busy    = rst_n & ((bus.we & full) | (bus.re & hit));
    assign bus.rd_data = (rst_n & bus.re) ? mem[ld_addr] : 16'h0000;
`endif

    assign push         = rst_n & bus.we & ~bus.busy;
    assign bus.wb_empty = (count == '0) && (state == IDLE);

    always_comb begin
        state_nxt       = state;
        drain_cnt_nxt   = drain_cnt;
        pop             = 1'b0;
        count_after_pop = count + CW'(push) - CW'(1);
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nxt     = WRITE;
                    drain_cnt_nxt = DCW'(DRAIN_CYC - 1);
                end
            end
            WRITE: begin
                if (drain_cnt == '0) begin
                    pop = 1'b1;
                    if (count_after_pop != '0) begin
                        state_nxt     = WRITE;
                        drain_cnt_nxt = DCW'(DRAIN_CYC - 1);
                    end else begin
                        state_nxt     = IDLE;
                        drain_cnt_nxt = '0;
                    end
                end else begin
                    drain_cnt_nxt = drain_cnt - DCW'(1);
                end
            end
            default: begin
                state_nxt     = IDLE;
                drain_cnt_nxt = '0;
            end
        endcase
    end

    assign count_nxt = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            drain_cnt <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            count     <= count_nxt;
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
        end
    end

    // Payload storage is not reset; validity comes solely from head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[tail] <= ld_addr;
            wb_data[tail] <= bus.wrt_data;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            mem[wb_addr[head]] <= wb_data[head];
        end
    end
endmodule

// File: tb/tb_dm_resp.sv
// tb/tb_dm_resp.sv - scoreboard bench for dm_resp against a store-timeline reference model
module tb_dm_resp;
    localparam int MEM_AW    = 16;
    localparam int WB_DEPTH  = 4;
    localparam int DRAIN_CYC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_resp_if bus ();

    dm_resp #(
        .MEM_AW   (MEM_AW),
        .WB_DEPTH (WB_DEPTH),
        .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic        busy;
        logic        wb_empty;
        logic [15:0] rd;
        logic        chk_rd;
        string       tag;
    } exp_t;

    typedef struct {
        int          addr;
        logic [15:0] data;
        int          commit;
    } ent_t;

    exp_t        exp_q[$];
    ent_t        pend[$];
    logic [15:0] mem_m[int];
    int          cyc;
    int          checks;
    int          fails;

    // Stores whose commit edge has passed are now in the array.
    task automatic retire();
        ent_t e;
        while (pend.size() > 0 && pend[0].commit < cyc) begin
            e = pend.pop_front();
            mem_m[e.addr] = e.data;
        end
    endtask

    task automatic step(input logic r, input logic w, input int a, input logic [15:0] d,
                        input string tag, output logic acc);
        exp_t x;
        ent_t e;
        int   hit_i;
        retire();
        hit_i = -1;
        foreach (pend[i]) if (pend[i].addr == a) hit_i = i;
        x.busy = w && (pend.size() == WB_DEPTH);
`ifndef DM_RESP_FWD_EN
        if (r && hit_i >= 0) x.busy = 1'b1;
`endif
        x.wb_empty = (pend.size() == 0);
        x.tag      = tag;
        x.chk_rd   = 1'b1;
        x.rd       = 16'h0000;
        if (r) begin
`ifdef DM_RESP_FWD_EN
            if (hit_i >= 0) x.rd = pend[hit_i].data;
            else if (mem_m.exists(a)) x.rd = mem_m[a];
            else x.chk_rd = 1'b0;
`else
            if (x.busy || !mem_m.exists(a)) x.chk_rd = 1'b0;
            else x.rd = mem_m[a];
`endif
        end
        bus.re       = r;
        bus.we       = w;
        bus.addr     = 16'(a);
        bus.wrt_data = d;
        exp_q.push_back(x);
        @(posedge clk);
        acc = !x.busy;
        if (w && acc) begin
            e.addr = a;
            e.data = d;
            if (pend.size() > 0 && cyc <= pend[pend.size()-1].commit)
                e.commit = pend[pend.size()-1].commit + DRAIN_CYC;
            else
                e.commit = cyc + DRAIN_CYC + 1;
            pend.push_back(e);
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset(input int n);
        exp_t x;
        retire();
        pend.delete();
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.re       = 1'b1;
            bus.we       = 1'b1;
            bus.addr     = 16'h0018;
            bus.wrt_data = 16'hFFFF;
            x.busy       = 1'b0;
            x.wb_empty   = 1'b1;
            x.rd         = 16'h0000;
            x.chk_rd     = 1'b1;
            x.tag        = "reset";
            exp_q.push_back(x);
            @(posedge clk);
            cyc++;
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic store(input int a, input logic [15:0] d, input string tag);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 64) begin
            step(1'b0, 1'b1, a, d, tag, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            fails++;
            $display("FAIL %s: store not accepted after %0d cycles, want accepted", tag, n);
        end
    endtask

    task automatic load(input int a, input string tag);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 64) begin
            step(1'b1, 1'b0, a, 16'h0000, tag, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            fails++;
            $display("FAIL %s: load still stalled after %0d cycles, want served", tag, n);
        end
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        retire();
        while (pend.size() > 0 && n < 200) begin
            step(1'b0, 1'b0, 0, 16'h0000, "drain", acc);
            retire();
            n++;
        end
        step(1'b0, 1'b0, 0, 16'h0000, "drained", acc);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks++;
            if (bus.busy !== x.busy) begin
                fails++;
                $display("FAIL %s busy: got %b want %b (t=%0t)", x.tag, bus.busy, x.busy, $time);
            end
            checks++;
            if (bus.wb_empty !== x.wb_empty) begin
                fails++;
                $display("FAIL %s wb_empty: got %b want %b (t=%0t)", x.tag, bus.wb_empty, x.wb_empty, $time);
            end
            if (x.chk_rd) begin
                checks++;
                if (bus.rd_data !== x.rd) begin
                    fails++;
                    $display("FAIL %s rd_data: got %h want %h (t=%0t)", x.tag, bus.rd_data, x.rd, $time);
                end
            end
        end
    end

    initial begin
        logic acc;
        checks       = 0;
        fails        = 0;
        cyc          = 0;
        bus.re       = 1'b0;
        bus.we       = 1'b0;
        bus.addr     = 16'h0000;
        bus.wrt_data = 16'h0000;
        @(posedge clk);
        #1;
        do_reset(3);

        for (int a = 0; a < 32; a++) store(a, 16'($urandom), "init");
        drain();

        store(16'h0005, 16'hBEEF, "fwd_st");
        load(16'h0005, "fwd_ld");
        drain();
        load(16'h0005, "fwd_ld_arr");

        store(16'h0007, 16'h1111, "nm_st1");
        store(16'h0007, 16'h2222, "nm_st2");
        load(16'h0007, "nm_ld");
        drain();
        load(16'h0007, "nm_ld_arr");

        for (int i = 0; i < 6; i++) store(8 + i, 16'hC000 + 16'(i), "burst");
        drain();
        for (int i = 0; i < 6; i++) load(8 + i, "burst_ld");

        store(16'h0010, 16'h00AA, "rw_pre");
        drain();
        step(1'b1, 1'b1, 16'h0010, 16'h00BB, "rw_same", acc);
        load(16'h0010, "rw_next");
        drain();

        store(16'h0014, 16'h1234, "nofwd_st");
        load(16'h0014, "nofwd_ld");
        drain();

        store(16'h0018, 16'h5A01, "rst_st");
        store(16'h0019, 16'h5A02, "rst_st");
        store(16'h001A, 16'h5A03, "rst_st");
        do_reset(2);
        load(16'h0018, "rst_old");
        load(16'h001A, "rst_old");

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 31), 16'($urandom), "rand", acc);
        end
        drain();
        for (int a = 0; a < 32; a++) load(a, "final");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL scoreboard: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
